// File: rtl/onehot_pkg.sv
// Shared types and elaboration-time helpers for the one-hot feeder and its encoder.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Euclid's algorithm; 64 rounds is far more than any 32-bit pair needs.
  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    for (int i = 0; i < 64; i++) begin
      if (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
    end
    return x;
  endfunction

  function automatic bit params_legal(input int n, input int stride, input int start,
                                      input int gate, input int pre_a, input int pre_b);
    bit ok;
    ok = 1'b1;
    if (n < 2) ok = 1'b0;
    if (stride < 1 || stride >= n) ok = 1'b0;
    if (ok && gcd(stride, n) != 1) ok = 1'b0;
    if (start < 0 || start >= n) ok = 1'b0;
    if (gate < 0 || gate >= n) ok = 1'b0;
    if (pre_a < 0 || pre_a >= n) ok = 1'b0;
    if (pre_b < 0 || pre_b >= n) ok = 1'b0;
    if (gate == pre_a || gate == pre_b) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/onehot_feeder_encoder.sv
// Index to one-hot word conversion; drives all zeros when en is low.
module onehot_encoder
  import onehot_pkg::*;
#(
  parameter int N = 2016,
  localparam int IW = idx_width(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  x
);

  always_comb begin
    x = '0;
    for (int i = 0; i < N; i++) begin
      x[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/onehot_feeder.sv
// Walks every index of an N-bit vector once and offers each as a one-hot beat,
// holding GATE_IDX back until PRE_A or PRE_B has been accepted.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | walking; one beat offered per cycle, bubble on a deferred gate
//   DONE  | all N beats accepted, waiting for start to replay
module onehot_feeder
  import onehot_pkg::*;
#(
  parameter int N        = 2016,
  parameter int STRIDE   = 1,
  parameter int START    = 0,
  parameter int GATE_IDX = 686,
  parameter int PRE_A    = 2015,
  parameter int PRE_B    = 2000,
  localparam int IW = idx_width(N),
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_x,
  output logic [IW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sent_count
);

  if (!params_legal(N, STRIDE, START, GATE_IDX, PRE_A, PRE_B)) begin : g_bad_params
    $error("onehot_feeder: illegal N/STRIDE/START/GATE_IDX/PRE_A/PRE_B combination");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] left_q;
  logic [N-1:0]  covered_q;
  logic          defer_q;
  logic [CW-1:0] sent_q;

  logic          pre_ok;
  logic          walk_live;
  logic          use_defer;
  logic          skip_gate;
  logic          valid;
  logic          fire;
  logic          last_beat;
  logic          load;
  logic [IW-1:0] cand_idx;
  logic [IW:0]   ptr_sum;
  logic [IW-1:0] ptr_adv;

  assign pre_ok    = covered_q[PRE_A] | covered_q[PRE_B];
  assign walk_live = (left_q != '0);
  assign last_beat = (sent_q == CW'(N - 1));
  assign load      = (state_q != RUN) && start;
  assign fire      = valid && out_ready;

  // Wrap-around add in one extra bit so p + STRIDE never overflows before the compare.
  always_comb begin
    ptr_sum = {1'b0, ptr_q} + (IW+1)'(STRIDE);
    if (ptr_sum >= (IW+1)'(N)) begin
      ptr_adv = IW'(ptr_sum - (IW+1)'(N));
    end else begin
      ptr_adv = IW'(ptr_sum);
    end
  end

  always_comb begin
    state_d   = state_q;
    use_defer = 1'b0;
    skip_gate = 1'b0;
    valid     = 1'b0;
    cand_idx  = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (defer_q && pre_ok) begin
          use_defer = 1'b1;
          valid     = 1'b1;
          cand_idx  = IW'(GATE_IDX);
        end else if (walk_live) begin
          if (ptr_q == IW'(GATE_IDX) && !pre_ok) begin
            skip_gate = 1'b1;
          end else begin
            valid    = 1'b1;
            cand_idx = ptr_q;
          end
        end
        if (valid && out_ready && last_beat) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // left_q counts walk positions still to visit, including the skipped gate slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(START);
      left_q    <= '0;
      covered_q <= '0;
      defer_q   <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ptr_q     <= IW'(START);
        left_q    <= CW'(N);
        covered_q <= '0;
        defer_q   <= 1'b0;
        sent_q    <= '0;
      end else if (skip_gate) begin
        defer_q <= 1'b1;
        ptr_q   <= ptr_adv;
        left_q  <= left_q - CW'(1);
      end else if (fire) begin
        covered_q[cand_idx] <= 1'b1;
        sent_q              <= sent_q + CW'(1);
        if (use_defer) begin
          defer_q <= 1'b0;
        end else begin
          ptr_q  <= ptr_adv;
          left_q <= left_q - CW'(1);
        end
      end
    end
  end

  onehot_encoder #(.N(N)) u_enc (
    .idx (cand_idx),
    .en  (valid),
    .x   (out_x)
  );

  assign out_valid  = valid;
  assign out_idx    = cand_idx;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign sent_count = sent_q;

  a_no_repeat: assert property (@(posedge clk) disable iff (rst)
    fire |-> !covered_q[cand_idx]);

  a_gate_order: assert property (@(posedge clk) disable iff (rst)
    (fire && cand_idx == IW'(GATE_IDX)) |-> pre_ok);

endmodule
